// File: rtl/fu_issue_arbiter_if.sv
// Issue-stage bus between RS select logic (master) and the FU issue arbiter (slave).
// Carries requests/tags, grants, flush and per-unit issue/completion status.
interface fu_issue_arbiter_if #(
   parameter int unsigned NUM_REQ = 8,
   parameter int unsigned NUM_FU  = 2,
   parameter int unsigned TAG_W   = 4
);
   localparam int unsigned FREE_W = $clog2(NUM_FU + 1);

   logic                      flush;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*TAG_W-1:0]  req_tag;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_FU-1:0]         fu_issue_valid;
   logic [NUM_FU*TAG_W-1:0]   fu_issue_tag;
   logic [NUM_FU-1:0]         fu_done;
   logic [NUM_FU-1:0]         fu_busy;
   logic [FREE_W-1:0]         free_cnt;

   modport master (
      output flush, req, req_tag,
      input  gnt, fu_issue_valid, fu_issue_tag, fu_done, fu_busy, free_cnt
   );

   modport slave (
      input  flush, req, req_tag,
      output gnt, fu_issue_valid, fu_issue_tag, fu_done, fu_busy, free_cnt
   );
endinterface

// File: rtl/fu_issue_arbiter.sv
// Multi-grant issue arbiter sharing NUM_FU multi-cycle units among NUM_REQ requesters.
// Optional FU_ARB_ROTATE_EN adds a rotating priority pointer for starvation freedom.
module fu_issue_arbiter #(
   parameter int unsigned NUM_REQ = 8,
   parameter int unsigned NUM_FU  = 2,
   parameter int unsigned FU_LAT  = 3,
   parameter int unsigned TAG_W   = 4
) (
   input logic               clock,
   input logic               reset_n,
   fu_issue_arbiter_if.slave bus
);
   localparam int unsigned CNT_W  = $clog2(FU_LAT + 1);
   localparam int unsigned FREE_W = $clog2(NUM_FU + 1);
   localparam int unsigned IDX_W  = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FU_LAT);

   typedef enum logic {StIdle, StBusy} fu_state_e;

   fu_state_e          state_q [NUM_FU];
   fu_state_e          state_d [NUM_FU];
   logic [CNT_W-1:0]   cnt_q   [NUM_FU];
   logic [CNT_W-1:0]   cnt_d   [NUM_FU];
   logic [TAG_W-1:0]   tag_q   [NUM_FU];
   logic [TAG_W-1:0]   tag_d   [NUM_FU];
   logic [TAG_W-1:0]   load_tag[NUM_FU];
   logic [TAG_W-1:0]   tag_in  [NUM_REQ];
   logic [NUM_FU-1:0]  issue_q, issue_d;
   logic [NUM_FU-1:0]  free, load, done, busy;
   logic [NUM_REQ-1:0] gnt;
   logic [FREE_W-1:0]  free_cnt;
   logic [NUM_FU*TAG_W-1:0] issue_tag;

`ifdef FU_ARB_ROTATE_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) tag_in[i] = bus.req_tag[i*TAG_W +: TAG_W];
   end

   // A unit finishing this cycle is already free, enabling back-to-back issue.
   always_comb begin
      free_cnt = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         busy[f] = (state_q[f] == StBusy);
         free[f] = (state_q[f] == StIdle) || (busy[f] && cnt_q[f] == CNT_ONE);
         done[f] = busy[f] && (cnt_q[f] == CNT_ONE) && !bus.flush;
         issue_tag[f*TAG_W +: TAG_W] = tag_q[f];
         free_cnt = free_cnt + FREE_W'(free[f]);
      end
   end

   // Walk requesters in MSB/LSB alternating order; each hit takes the lowest free unit.
   always_comb begin
      logic [NUM_FU-1:0] avail;
      logic              taken;
      int unsigned       base;
      int unsigned       ridx;
      logic [IDX_W-1:0]  ri;
      gnt   = '0;
      load  = '0;
      avail = free & {NUM_FU{~bus.flush}};
      for (int f = 0; f < NUM_FU; f++) load_tag[f] = '0;
      for (int unsigned p = 0; p < NUM_REQ; p++) begin
         base = (p % 2 == 0) ? (NUM_REQ - 1 - p / 2) : (p / 2);
`ifdef FU_ARB_ROTATE_EN
         ridx = (base + int'(ptr_q)) % NUM_REQ;
`else
         ridx = base;
`endif
         ri    = IDX_W'(ridx);
         taken = 1'b0;
         if (bus.req[ri]) begin
            for (int f = 0; f < NUM_FU; f++) begin
               if (!taken && avail[f]) begin
                  taken       = 1'b1;
                  avail[f]    = 1'b0;
                  load[f]     = 1'b1;
                  load_tag[f] = tag_in[ri];
                  gnt[ri]     = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      issue_d = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         state_d[f] = state_q[f];
         cnt_d[f]   = cnt_q[f];
         tag_d[f]   = tag_q[f];
         if (bus.flush) begin
            state_d[f] = StIdle;
            cnt_d[f]   = '0;
         end else if (load[f]) begin
            state_d[f] = StBusy;
            cnt_d[f]   = CNT_LOAD;
            tag_d[f]   = load_tag[f];
            issue_d[f] = 1'b1;
         end else if (state_q[f] == StBusy) begin
            if (cnt_q[f] == CNT_ONE) begin
               state_d[f] = StIdle;
               cnt_d[f]   = '0;
            end else begin
               cnt_d[f] = cnt_q[f] - CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int f = 0; f < NUM_FU; f++) begin
            state_q[f] <= StIdle;
            cnt_q[f]   <= '0;
            tag_q[f]   <= '0;
         end
         issue_q <= '0;
      end else begin
         for (int f = 0; f < NUM_FU; f++) begin
            state_q[f] <= state_d[f];
            cnt_q[f]   <= cnt_d[f];
            tag_q[f]   <= tag_d[f];
         end
         issue_q <= issue_d;
      end
   end

`ifdef FU_ARB_ROTATE_EN
   always_comb begin
      ptr_d = ptr_q;
      if (bus.flush) begin
         ptr_d = '0;
      end else if (|gnt) begin
         ptr_d = (ptr_q == IDX_W'(NUM_REQ - 1)) ? '0 : ptr_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end
`endif

   assign bus.gnt            = gnt;
   assign bus.fu_issue_valid = issue_q;
   assign bus.fu_issue_tag   = issue_tag;
   assign bus.fu_done        = done;
   assign bus.fu_busy        = busy;
   assign bus.free_cnt       = free_cnt;
endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed bench for fu_issue_arbiter: a 2-unit FU_LAT=3 instance and a 1-unit FU_LAT=1 instance.
// Tag of requester i is i, so routed tags identify the granted requester.
module tb_fu_issue_arbiter;
   logic clock = 1'b0;
   logic reset_n;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clock = ~clock;

   fu_issue_arbiter_if #(.NUM_REQ(8), .NUM_FU(2), .TAG_W(4)) bus_a ();
   fu_issue_arbiter_if #(.NUM_REQ(8), .NUM_FU(1), .TAG_W(4)) bus_b ();

   fu_issue_arbiter #(.NUM_REQ(8), .NUM_FU(2), .FU_LAT(3), .TAG_W(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   fu_issue_arbiter #(.NUM_REQ(8), .NUM_FU(1), .FU_LAT(1), .TAG_W(4)) dut_lat1 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_total++; if (bus_a.gnt !== 8'h00) $display("FAIL rst_gnt got %h want 00", bus_a.gnt); else n_pass++;
      n_total++; if (bus_a.free_cnt !== 2'd2) $display("FAIL rst_free got %0d want 2", bus_a.free_cnt); else n_pass++;
      n_total++; if (bus_a.fu_busy !== 2'b00) $display("FAIL rst_busy got %b want 00", bus_a.fu_busy); else n_pass++;
      n_total++; if (bus_a.fu_issue_valid !== 2'b00) $display("FAIL rst_iv got %b want 00", bus_a.fu_issue_valid); else n_pass++;
      n_total++; if (bus_a.fu_done !== 2'b00) $display("FAIL rst_done got %b want 00", bus_a.fu_done); else n_pass++;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_full_req();
      bus_a.req = 8'hFF; #1;
      n_total++; if (bus_a.gnt !== 8'h81) $display("FAIL full_gnt got %h want 81", bus_a.gnt); else n_pass++;
      step(); bus_a.req = 8'h7E; #1;
      n_total++; if (bus_a.gnt !== 8'h00) $display("FAIL full_gnt_busy got %h want 00", bus_a.gnt); else n_pass++;
      n_total++; if (bus_a.fu_issue_valid !== 2'b11) $display("FAIL full_iv got %b want 11", bus_a.fu_issue_valid); else n_pass++;
      n_total++; if (bus_a.fu_issue_tag !== 8'h07) $display("FAIL full_tag got %h want 07", bus_a.fu_issue_tag); else n_pass++;
      n_total++; if (bus_a.free_cnt !== 2'd0) $display("FAIL full_free got %0d want 0", bus_a.free_cnt); else n_pass++;
      step(); #1;
      n_total++; if (bus_a.fu_issue_valid !== 2'b00) $display("FAIL full_iv_pulse got %b want 00", bus_a.fu_issue_valid); else n_pass++;
      n_total++; if (bus_a.fu_done !== 2'b00) $display("FAIL full_done_early got %b want 00", bus_a.fu_done); else n_pass++;
      step(); #1;
      n_total++; if (bus_a.fu_done !== 2'b11) $display("FAIL full_done got %b want 11", bus_a.fu_done); else n_pass++;
      n_total++; if (bus_a.free_cnt !== 2'd2) $display("FAIL full_free_done got %0d want 2", bus_a.free_cnt); else n_pass++;
      n_total++; if (bus_a.gnt !== 8'h42) $display("FAIL full_b2b_gnt got %h want 42", bus_a.gnt); else n_pass++;
      step(); bus_a.req = 8'h00; #1;
      n_total++; if (bus_a.fu_issue_valid !== 2'b11) $display("FAIL full_b2b_iv got %b want 11", bus_a.fu_issue_valid); else n_pass++;
      n_total++; if (bus_a.fu_issue_tag !== 8'h16) $display("FAIL full_b2b_tag got %h want 16", bus_a.fu_issue_tag); else n_pass++;
      step(); step(); step(); #1;
      n_total++; if (bus_a.fu_busy !== 2'b00) $display("FAIL full_drain got %b want 00", bus_a.fu_busy); else n_pass++;
   endtask

   task automatic test_pair();
      bus_a.req = 8'h0C; #1;
      n_total++; if (bus_a.gnt !== 8'h0C) $display("FAIL pair_gnt got %h want 0c", bus_a.gnt); else n_pass++;
      n_total++; if (bus_a.free_cnt !== 2'd2) $display("FAIL pair_free0 got %0d want 2", bus_a.free_cnt); else n_pass++;
      step(); bus_a.req = 8'h00; #1;
      n_total++; if (bus_a.free_cnt !== 2'd0) $display("FAIL pair_free1 got %0d want 0", bus_a.free_cnt); else n_pass++;
      // requester 2 precedes 3 in the alternating order, so unit0 holds tag 2
      n_total++; if (bus_a.fu_issue_tag !== 8'h32) $display("FAIL pair_tag got %h want 32", bus_a.fu_issue_tag); else n_pass++;
      step(); step(); step(); #1;
      n_total++; if (bus_a.fu_busy !== 2'b00) $display("FAIL pair_drain got %b want 00", bus_a.fu_busy); else n_pass++;
   endtask

   task automatic test_partial();
      bus_a.req = 8'h01; #1;
      n_total++; if (bus_a.gnt !== 8'h01) $display("FAIL part_gnt0 got %h want 01", bus_a.gnt); else n_pass++;
      step(); bus_a.req = 8'h00; #1;
      n_total++; if (bus_a.fu_busy !== 2'b01) $display("FAIL part_busy got %b want 01", bus_a.fu_busy); else n_pass++;
      step(); bus_a.req = 8'h11; #1;
      n_total++; if (bus_a.gnt !== 8'h01) $display("FAIL part_gnt1 got %h want 01", bus_a.gnt); else n_pass++;
      n_total++; if (bus_a.free_cnt !== 2'd1) $display("FAIL part_free got %0d want 1", bus_a.free_cnt); else n_pass++;
      step(); bus_a.req = 8'h10; #1;
      n_total++; if (bus_a.gnt !== 8'h10) $display("FAIL part_gnt2 got %h want 10", bus_a.gnt); else n_pass++;
      n_total++; if (bus_a.fu_done !== 2'b01) $display("FAIL part_done got %b want 01", bus_a.fu_done); else n_pass++;
      n_total++; if (bus_a.fu_issue_valid !== 2'b10) $display("FAIL part_iv1 got %b want 10", bus_a.fu_issue_valid); else n_pass++;
      step(); bus_a.req = 8'h00; #1;
      n_total++; if (bus_a.fu_issue_valid !== 2'b01) $display("FAIL part_iv0 got %b want 01", bus_a.fu_issue_valid); else n_pass++;
      n_total++; if (bus_a.fu_issue_tag !== 8'h04) $display("FAIL part_tag got %h want 04", bus_a.fu_issue_tag); else n_pass++;
      n_total++; if (bus_a.fu_busy !== 2'b11) $display("FAIL part_busy2 got %b want 11", bus_a.fu_busy); else n_pass++;
      step(); step(); step(); #1;
      n_total++; if (bus_a.fu_busy !== 2'b00) $display("FAIL part_drain got %b want 00", bus_a.fu_busy); else n_pass++;
   endtask

   task automatic test_flush_reset();
      bus_a.req = 8'hFF; #1;
      n_total++; if (bus_a.gnt !== 8'h81) $display("FAIL fl_gnt0 got %h want 81", bus_a.gnt); else n_pass++;
      step(); bus_a.req = 8'h7E;
      step();
      step(); bus_a.req = 8'hFF; bus_a.flush = 1'b1; #1;
      n_total++; if (bus_a.gnt !== 8'h00) $display("FAIL fl_gnt got %h want 00", bus_a.gnt); else n_pass++;
      n_total++; if (bus_a.fu_done !== 2'b00) $display("FAIL fl_done got %b want 00", bus_a.fu_done); else n_pass++;
      n_total++; if (bus_a.fu_busy !== 2'b11) $display("FAIL fl_busy_pre got %b want 11", bus_a.fu_busy); else n_pass++;
      step(); bus_a.flush = 1'b0; bus_a.req = 8'h00; #1;
      n_total++; if (bus_a.fu_busy !== 2'b00) $display("FAIL fl_busy got %b want 00", bus_a.fu_busy); else n_pass++;
      n_total++; if (bus_a.fu_issue_valid !== 2'b00) $display("FAIL fl_iv got %b want 00", bus_a.fu_issue_valid); else n_pass++;
      n_total++; if (bus_a.free_cnt !== 2'd2) $display("FAIL fl_free got %0d want 2", bus_a.free_cnt); else n_pass++;
      bus_a.req = 8'h01;
      step(); bus_a.req = 8'h00; #1;
      n_total++; if (bus_a.fu_issue_valid !== 2'b01) $display("FAIL ar_iv_pre got %b want 01", bus_a.fu_issue_valid); else n_pass++;
      #2; reset_n = 1'b0; #1;
      n_total++; if (bus_a.fu_busy !== 2'b00) $display("FAIL ar_busy got %b want 00", bus_a.fu_busy); else n_pass++;
      n_total++; if (bus_a.fu_issue_valid !== 2'b00) $display("FAIL ar_iv got %b want 00", bus_a.fu_issue_valid); else n_pass++;
      #1; reset_n = 1'b1;
      step(); step(); #1;
      n_total++; if (bus_a.fu_done !== 2'b00) $display("FAIL ar_done got %b want 00", bus_a.fu_done); else n_pass++;
   endtask

   task automatic test_lat1();
      bus_b.req = 8'h01; #1;
      n_total++; if (bus_b.gnt !== 8'h01) $display("FAIL l1_gnt0 got %h want 01", bus_b.gnt); else n_pass++;
      for (int i = 1; i < 4; i++) begin
         step(); #1;
         n_total++; if (bus_b.gnt !== 8'h01) $display("FAIL l1_gnt%0d got %h want 01", i, bus_b.gnt); else n_pass++;
         n_total++; if (bus_b.fu_issue_valid !== 1'b1) $display("FAIL l1_iv%0d got %b want 1", i, bus_b.fu_issue_valid); else n_pass++;
         n_total++; if (bus_b.fu_done !== 1'b1) $display("FAIL l1_done%0d got %b want 1", i, bus_b.fu_done); else n_pass++;
      end
      step(); bus_b.req = 8'h00; #1;
      n_total++; if (bus_b.fu_done !== 1'b1) $display("FAIL l1_done4 got %b want 1", bus_b.fu_done); else n_pass++;
      step(); #1;
      n_total++; if (bus_b.fu_busy !== 1'b0) $display("FAIL l1_idle got %b want 0", bus_b.fu_busy); else n_pass++;
   endtask

`ifdef FU_ARB_ROTATE_EN
   task automatic test_rotate();
      logic [7:0] seen;
      logic [7:0] exp_gnt;
      seen = 8'h00;
      reset_n = 1'b0; #1; reset_n = 1'b1;
      step();
      bus_b.req = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         #1;
         exp_gnt = 8'h01 << ((7 + k) % 8);
         n_total++; if (bus_b.gnt !== exp_gnt) $display("FAIL rot_gnt%0d got %h want %h", k, bus_b.gnt, exp_gnt); else n_pass++;
         seen = seen | bus_b.gnt;
         step();
      end
      bus_b.req = 8'h00;
      n_total++; if (seen !== 8'hFF) $display("FAIL rot_all got %h want ff", seen); else n_pass++;
      step(); step();
   endtask
`endif

   initial begin
      reset_n       = 1'b0;
      bus_a.flush   = 1'b0;
      bus_a.req     = 8'h00;
      bus_a.req_tag = 32'h7654_3210;
      bus_b.flush   = 1'b0;
      bus_b.req     = 8'h00;
      bus_b.req_tag = 32'h7654_3210;
      test_reset();
      test_full_req();
      test_pair();
      test_partial();
      test_flush_reset();
      test_lat1();
`ifdef FU_ARB_ROTATE_EN
      test_rotate();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
